// File: rtl/hamming_decode_scheduler_pkg.sv
// Shared types and the Hamming(7,4) syndrome helper for the decode scheduler.
// Codeword bit k-1 holds Hamming position k.
package hds_pkg;

  localparam int CW_W = 7;
  localparam int DW   = 4;

  typedef logic [CW_W-1:0] codeword_t;
  typedef logic [DW-1:0]   nibble_t;

  // Returns {s3,s2,s1}; pt=1 selects odd parity.
  function automatic logic [2:0] syndrome(input codeword_t c, input logic pt);
    return {c[3] ^ c[4] ^ c[5] ^ c[6] ^ pt,
            c[1] ^ c[2] ^ c[5] ^ c[6] ^ pt,
            c[0] ^ c[2] ^ c[4] ^ c[6] ^ pt};
  endfunction

endpackage

// File: rtl/hamming_decode_scheduler_if.sv
// Codeword request streams in, corrected tagged results out.
// master = upstream/downstream side, slave = the scheduler.
interface hamming_decode_scheduler_if #(
  parameter int N_CH = 4
);
  import hds_pkg::*;

  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]      in_valid;
  logic [CW_W*N_CH-1:0] in_code;
  logic [N_CH-1:0]      in_ready;
  logic                 out_valid;
  logic                 out_ready;
  nibble_t              out_data;
  logic [CH_W-1:0]      out_ch;
  logic                 out_err;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_err
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_err
  );

endinterface

// File: rtl/hamming_decode_scheduler_correct.sv
// Combinational Hamming(7,4) single-error corrector; returns {c7,c6,c5,c3}.
// Only data positions are ever repaired, so parity-bit syndromes just raise err.
module hamming74_correct
  import hds_pkg::*;
(
  input  codeword_t code,
  input  logic      parity_type,
  output nibble_t   data,
  output logic      err
);

  logic [2:0] syn;

  always_comb begin
    syn     = syndrome(code, parity_type);
    data[3] = code[6] ^ (syn == 3'd7);
    data[2] = code[5] ^ (syn == 3'd6);
    data[1] = code[4] ^ (syn == 3'd5);
    data[0] = code[2] ^ (syn == 3'd3);
    err     = (syn != 3'd0);
  end

endmodule

// File: rtl/hamming_decode_scheduler.sv
// Round-robin scheduler sharing one Hamming(7,4) corrector between N_CH channels.
// Define HDS_ERR_COUNT_EN to add per-channel saturating error counters (clr_cnt/err_cnt).
module hamming_decode_scheduler
  import hds_pkg::*;
#(
  parameter int N_CH = 4
`ifdef HDS_ERR_COUNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic parity_type,
`ifdef HDS_ERR_COUNT_EN
  input  logic                  clr_cnt,
  output logic [CNT_W*N_CH-1:0] err_cnt,
`endif
  hamming_decode_scheduler_if.slave bus
);

  localparam int CH_W = $clog2(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            out_valid_q, out_valid_d;
  nibble_t         out_data_q, out_data_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;
  logic            out_err_q, out_err_d;

  logic            adv;
  logic            found;
  logic [CH_W-1:0] gnt_idx;
  logic [N_CH-1:0] grant;
  codeword_t       code_sel;
  nibble_t         dec_data;
  logic            dec_err;

  function automatic logic [CH_W-1:0] ch_at(input logic [CH_W-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_CH) s = s - N_CH;
    return CH_W'(s);
  endfunction

  // Priority search starting at rr_ptr, wrapping past the last channel.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && bus.in_valid[ch_at(rr_ptr_q, i)]) begin
        found   = 1'b1;
        gnt_idx = ch_at(rr_ptr_q, i);
      end
    end
    grant = '0;
    if (found) grant[gnt_idx] = 1'b1;
  end

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = grant & {N_CH{adv}};
  assign code_sel     = bus.in_code[32'(gnt_idx)*CW_W +: CW_W];

  hamming74_correct u_correct (
    .code        (code_sel),
    .parity_type (parity_type),
    .data        (dec_data),
    .err         (dec_err)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_err_d   = out_err_q;
    rr_ptr_d    = rr_ptr_q;
    if (adv) begin
      out_valid_d = found;
      if (found) begin
        out_data_d = dec_data;
        out_ch_d   = gnt_idx;
        out_err_d  = dec_err;
        rr_ptr_d   = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_err_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_err_q   <= out_err_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_err   = out_err_q;

`ifdef HDS_ERR_COUNT_EN
  logic [CNT_W-1:0] err_cnt_q [N_CH];
  logic [CNT_W-1:0] err_cnt_d [N_CH];

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      err_cnt_d[i] = err_cnt_q[i];
      if (clr_cnt) begin
        err_cnt_d[i] = '0;
      end else if (adv && found && dec_err && gnt_idx == CH_W'(i) && err_cnt_q[i] != '1) begin
        err_cnt_d[i] = err_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) err_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) err_cnt_q[i] <= err_cnt_d[i];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    assign err_cnt[g*CNT_W +: CNT_W] = err_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_hamming_decode_scheduler.sv
// Self-checking bench: nearest-codeword reference decoder plus round-robin model,
// directed literal cases and randomized traffic with stalls.
module tb_hamming_decode_scheduler;
  import hds_pkg::*;

  localparam int N_CH    = 4;
  localparam int CH_W    = $clog2(N_CH);
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic parity_type = 1'b0;

  always #5 clk = ~clk;

  hamming_decode_scheduler_if #(.N_CH(N_CH)) bus ();

`ifdef HDS_ERR_COUNT_EN
  logic                  clr_cnt = 1'b0;
  logic [CNT_W*N_CH-1:0] err_cnt;
`endif

  hamming_decode_scheduler #(.N_CH(N_CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .parity_type (parity_type),
`ifdef HDS_ERR_COUNT_EN
    .clr_cnt     (clr_cnt),
    .err_cnt     (err_cnt),
`endif
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  bit      m_vld;
  nibble_t m_data;
  int      m_ch;
  bit      m_err;
  int      m_rr;
  int      m_cnt [N_CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic codeword_t encode(input nibble_t d, input logic pt);
    codeword_t c;
    c    = '0;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[0] = c[2] ^ c[4] ^ c[6] ^ pt;
    c[1] = c[2] ^ c[5] ^ c[6] ^ pt;
    c[3] = c[4] ^ c[5] ^ c[6] ^ pt;
    return c;
  endfunction

  // Search every valid codeword and every single-bit flip of it.
  task automatic ref_decode(input codeword_t c, input logic pt,
                            output nibble_t d, output bit e, output bit ok);
    codeword_t cand;
    ok = 1'b0;
    d  = '0;
    e  = 1'b0;
    for (int dd = 0; dd < 16; dd++) begin
      for (int f = 0; f < 8; f++) begin
        cand = encode(4'(dd), pt);
        if (f != 0) cand[f-1] = ~cand[f-1];
        if (cand == c && !ok) begin
          ok = 1'b1;
          d  = 4'(dd);
          e  = (f != 0);
        end
      end
    end
  endtask

  function automatic int model_grant(input logic [N_CH-1:0] v, input int rr);
    for (int k = 0; k < N_CH; k++) begin
      if (v[(rr + k) % N_CH]) return (rr + k) % N_CH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_vld  = 1'b0;
    m_data = '0;
    m_ch   = 0;
    m_err  = 1'b0;
    m_rr   = 0;
    for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
  endtask

  // Called just after a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step(output int acc_g);
    int              g;
    bit              adv;
    bit              clr_now;
    nibble_t         d;
    bit              e;
    bit              ok;
    logic [N_CH-1:0] exp_rdy;
    codeword_t       cw;
    #1;
    adv = !m_vld || bus.out_ready;
    g   = model_grant(bus.in_valid, m_rr);
    exp_rdy = '0;
    if (adv && g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    d = '0;
    e = 1'b0;
    if (adv && g >= 0) begin
      cw = bus.in_code[g*CW_W +: CW_W];
      ref_decode(cw, parity_type, d, e, ok);
      if (!ok) begin
        errors++;
        $display("FAIL ref_decode: no codeword near %b", cw);
      end
    end
    clr_now = 1'b0;
`ifdef HDS_ERR_COUNT_EN
    clr_now = clr_cnt;
`endif
    acc_g = -1;
    @(posedge clk);
    if (adv) begin
      m_vld = (g >= 0);
      if (g >= 0) begin
        m_data = d;
        m_ch   = g;
        m_err  = e;
        m_rr   = (g + 1) % N_CH;
        acc_g  = g;
      end
    end
    if (clr_now) begin
      for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
    end else if (acc_g >= 0 && e && m_cnt[acc_g] < CNT_MAX) begin
      m_cnt[acc_g]++;
    end
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
    chk("out_data",  32'(bus.out_data),  32'(m_data));
    chk("out_ch",    32'(bus.out_ch),    32'(m_ch));
    chk("out_err",   32'(bus.out_err),   32'(m_err));
`ifdef HDS_ERR_COUNT_EN
    for (int i = 0; i < N_CH; i++)
      chk("err_cnt", 32'(err_cnt[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
`endif
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic randomize_inputs(input int last_g);
    logic [N_CH-1:0]      v;
    logic [CW_W*N_CH-1:0] c;
    v = bus.in_valid;
    c = bus.in_code;
    for (int i = 0; i < N_CH; i++) begin
      if (v[i] && i != last_g) begin
        if ($urandom_range(0, 7) == 0) v[i] = 1'b0;
      end else begin
        v[i] = ($urandom_range(0, 1) == 1);
        c[i*CW_W +: CW_W] = CW_W'($urandom);
      end
    end
    bus.in_valid  = v;
    bus.in_code   = c;
    bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int g;
    bus.in_valid  = '0;
    bus.in_code   = '0;
    bus.out_ready = 1'b1;
    model_reset();

    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_ch",    32'(bus.out_ch),    32'd0);
    chk("rst_out_err",   32'(bus.out_err),   32'd0);
    rst_n = 1'b1;

    // Clean codeword on channel 0, even parity
    bus.in_valid = 4'b0001;
    bus.in_code[0 +: 7] = 7'b1100110;
    step(g);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_data",  32'(bus.out_data),  32'b1101);
    chk("t1_ch",    32'(bus.out_ch),    32'd0);
    chk("t1_err",   32'(bus.out_err),   32'd0);

    // Position 5 flipped on channel 2
    bus.in_valid = 4'b0100;
    bus.in_code[14 +: 7] = 7'b1110110;
    step(g);
    chk("t2_data", 32'(bus.out_data), 32'b1101);
    chk("t2_ch",   32'(bus.out_ch),   32'd2);
    chk("t2_err",  32'(bus.out_err),  32'd1);
`ifdef HDS_ERR_COUNT_EN
    chk("t2_cnt", 32'(err_cnt[16 +: 8]), 32'd1);
`endif

    // Odd parity, channel 1
    parity_type = 1'b1;
    bus.in_valid = 4'b0010;
    bus.in_code[7 +: 7] = 7'b1101101;
    step(g);
    chk("t3_data", 32'(bus.out_data), 32'b1101);
    chk("t3_ch",   32'(bus.out_ch),   32'd1);
    chk("t3_err",  32'(bus.out_err),  32'd0);
    bus.in_valid = '0;
    parity_type  = 1'b0;
    step(g);

    // Traffic, then asynchronous reset between edges
    bus.in_valid = '1;
    bus.in_code  = 28'(32'($urandom));
    step(g);
    step(g);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_ch",    32'(bus.out_ch),    32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // All channels requesting: rotation from 0
    for (int k = 0; k < 6; k++) begin
      step(g);
      chk("rr_seq_ch",    32'(bus.out_ch),    32'(k % N_CH));
      chk("rr_seq_valid", 32'(bus.out_valid), 32'd1);
    end

    // Stall for three cycles, then release
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(g);
      chk("stall_ch", 32'(bus.out_ch), 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_ready", 32'(bus.in_ready), 32'b0100);
    step(g);
    chk("release_ch", 32'(bus.out_ch), 32'd2);

`ifdef HDS_ERR_COUNT_EN
    // Saturation, then clear against a same-cycle error
    do_reset();
    bus.in_valid = 4'b0001;
    bus.in_code[0 +: 7] = 7'b1110110;
    for (int k = 0; k < CNT_MAX + 2; k++) step(g);
    chk("cnt_sat", 32'(err_cnt[0 +: 8]), 32'hFF);
    clr_cnt = 1'b1;
    step(g);
    clr_cnt = 1'b0;
    chk("cnt_clr", 32'(err_cnt[0 +: 8]), 32'd0);
`endif

    // Randomized traffic under both parity types
    for (int p = 0; p < 2; p++) begin
      parity_type = p[0];
      do_reset();
      g = -1;
      for (int k = 0; k < 1000; k++) begin
        randomize_inputs(g);
`ifdef HDS_ERR_COUNT_EN
        clr_cnt = ($urandom_range(0, 31) == 0);
`endif
        step(g);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
